// File: rtl/button_pkg.sv
// Shared types and timing defaults for the push-button conditioning path.
package button_pkg;

  // Per-channel hold tracking state.
  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StHeld
  } btn_state_e;

  // Default timing at a 100 MHz system clock.
  localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;
  localparam int unsigned LONG_500MS_100MHZ    = 50000000;
  localparam int unsigned REPEAT_100MS_100MHZ  = 10000000;

  // Counter width wide enough for the largest terminal count (max - 1).
  function automatic int unsigned CNT_W(input int unsigned deb_cycles,
                                        input int unsigned long_cycles,
                                        input int unsigned rep_cycles);
    int unsigned m;
    m = 2;
    if (deb_cycles > m) m = deb_cycles;
    if (long_cycles > m) m = long_cycles;
    if (rep_cycles > m) m = rep_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, counting debouncer and press/hold FSM.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_500MS_100MHZ,
  parameter int unsigned REPEAT_CYCLES     = REPEAT_100MS_100MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned W = CNT_W(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES);

  localparam logic [W-1:0] DebLast  = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] LongLast = W'(LONG_PRESS_CYCLES - 1);
  // Unused when repeat is disabled; kept in range to avoid underflow.
  localparam logic [W-1:0] RepLast  = (REPEAT_CYCLES > 0) ? W'(REPEAT_CYCLES - 1) : '0;

  logic sync1, sync2;

  logic         stable_q, stable_d;
  logic [W-1:0] deb_cnt_q, deb_cnt_d;
  logic         rise, fall;

  btn_state_e   state_q, state_d;
  logic [W-1:0] hold_cnt_q, hold_cnt_d;
  logic         press_d, release_d, long_d, repeat_d;

  // Bring the asynchronous pin into the clock domain; sync1 feeds nothing but sync2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    deb_cnt_d = '0;
    stable_d  = stable_q;
    rise      = 1'b0;
    fall      = 1'b0;
    if (sync2 != stable_q) begin
      if (deb_cnt_q == DebLast) begin
        stable_d = sync2;
        rise     = sync2;
        fall     = ~sync2;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Press/hold FSM; a completing release overrides any long/repeat terminal count.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    if (fall) begin
      release_d  = 1'b1;
      hold_cnt_d = '0;
      state_d    = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            press_d    = 1'b1;
            hold_cnt_d = '0;
            state_d    = StPressed;
          end
        end
        StPressed: begin
          if (hold_cnt_q == LongLast) begin
            long_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = StHeld;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (REPEAT_CYCLES > 0) begin
            if (hold_cnt_q == RepLast) begin
              repeat_d   = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          hold_cnt_d = '0;
          state_d    = StIdle;
        end
      endcase
    end
  end

  // FSM state and registered pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      hold_cnt_q    <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
    end
  end

  assign btn_level = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN independent raw push-buttons into clean levels and event pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BTN             = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_500MS_100MHZ,
  parameter int unsigned REPEAT_CYCLES     = REPEAT_100MS_100MHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_raw[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: expected pulse events are queued with their cycle and matched as they appear.
module tb_button_conditioner;

  localparam int KPress   = 0;
  localparam int KRelease = 1;
  localparam int KLong    = 2;
  localparam int KRepeat  = 3;

  typedef struct {
    int ch;
    int kind;
    int at;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_raw, btn_raw_nr;
  logic [1:0] btn_level, press_pulse, release_pulse, long_press, repeat_pulse;
  logic [1:0] lvl_nr, prs_nr, rel_nr, lng_nr, rep_nr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q_main[$];
  ev_t  q_nr[$];
  int   c, p, cr;

  button_conditioner #(
    .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  button_conditioner #(
    .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .REPEAT_CYCLES(0)
  ) dut_nr (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw_nr),
    .btn_level    (lvl_nr),
    .press_pulse  (prs_nr),
    .release_pulse(rel_nr),
    .long_press   (lng_nr),
    .repeat_pulse (rep_nr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      KPress:   return "press";
      KRelease: return "release";
      KLong:    return "long";
      KRepeat:  return "repeat";
      default:  return "none";
    endcase
  endfunction

  function automatic void push_main(input int ch, input int k, input int at);
    ev_t e;
    e = '{ch, k, at};
    q_main.push_back(e);
  endfunction

  function automatic void push_nr(input int ch, input int k, input int at);
    ev_t e;
    e = '{ch, k, at};
    q_nr.push_back(e);
  endfunction

  // Every observed pulse must be the next queued expectation, on the right cycle.
  task automatic observe(input int which, input int ch, input logic [3:0] pv);
    ev_t e;
    for (int k = 0; k < 4; k++) begin
      if (pv[k] === 1'b1) begin
        if (which == 0 && q_main.size() > 0) e = q_main.pop_front();
        else if (which == 1 && q_nr.size() > 0) e = q_nr.pop_front();
        else e = '{-1, -1, -1};
        checks++;
        assert (e.ch == ch && e.kind == k && e.at == cyc) else begin
          errors++;
          $error("FAIL %s: observed ch%0d %s at cycle %0d, expected ch%0d %s at cycle %0d",
                 (which == 0) ? "pulse_main" : "pulse_norep", ch, kname(k), cyc,
                 e.ch, kname(e.kind), e.at);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int ch = 0; ch < 2; ch++) begin
        observe(0, ch, {repeat_pulse[ch], long_press[ch], release_pulse[ch], press_pulse[ch]});
        observe(1, ch, {rep_nr[ch], lng_nr[ch], rel_nr[ch], prs_nr[ch]});
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag, input logic [9:0] got);
    checks++;
    assert (got === 10'b0) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, 10'b0);
    end
  endtask

  task automatic check_empty(input string tag, input int got);
    checks++;
    assert (got == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d pending events expected 0", tag, got);
    end
  endtask

  initial begin
    reset      = 1'b1;
    btn_raw    = 2'b00;
    btn_raw_nr = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_main", {btn_level, press_pulse, release_pulse, long_press, repeat_pulse});
    check_zero("reset_norep", {lvl_nr, prs_nr, rel_nr, lng_nr, rep_nr});
    reset = 1'b0;
    wait_cyc(cyc + 3);

    // Clean press on ch0, held into long press and repeats, then released.
    c = cyc;
    btn_raw[0] = 1'b1;
    p = c + 6;
    push_main(0, KPress, p);
    push_main(0, KLong, p + 10);
    for (int r = 13; r <= 28; r += 3) push_main(0, KRepeat, p + r);
    wait_cyc(p);
    @(negedge clk);
    check_bit("clean_level0", btn_level[0], 1'b1);
    check_bit("clean_level1", btn_level[1], 1'b0);
    wait_cyc(p - 1 + 1);
    wait_cyc(p + 24);
    btn_raw[0] = 1'b0;
    push_main(0, KRelease, p + 30);
    wait_cyc(p + 29);
    @(negedge clk);
    check_bit("held_level0", btn_level[0], 1'b1);
    wait_cyc(p + 30);
    @(negedge clk);
    check_bit("released_level0", btn_level[0], 1'b0);
    wait_cyc(p + 40);

    // Bounce on ch1: only the final settle produces a press.
    c = cyc;
    btn_raw[1] = 1'b1;
    wait_cyc(c + 2);
    btn_raw[1] = 1'b0;
    wait_cyc(c + 4);
    btn_raw[1] = 1'b1;
    wait_cyc(c + 6);
    btn_raw[1] = 1'b0;
    wait_cyc(c + 8);
    btn_raw[1] = 1'b1;
    push_main(1, KPress, c + 14);
    wait_cyc(c + 13);
    @(negedge clk);
    check_bit("bounce_level_before", btn_level[1], 1'b0);
    wait_cyc(c + 14);
    btn_raw[1] = 1'b0;
    push_main(1, KRelease, c + 20);
    wait_cyc(c + 26);

    // Release completes on the long-press terminal cycle: release only.
    c = cyc;
    btn_raw[0] = 1'b1;
    p = c + 6;
    push_main(0, KPress, p);
    wait_cyc(c + 10);
    btn_raw[0] = 1'b0;
    push_main(0, KRelease, p + 10);
    wait_cyc(p + 10);
    @(negedge clk);
    check_bit("collide_long", long_press[0], 1'b0);
    check_bit("collide_level", btn_level[0], 1'b0);
    wait_cyc(p + 20);

    // Reset while held: outputs clear at once, then a fresh press with no release.
    c = cyc;
    btn_raw[0] = 1'b1;
    p = c + 6;
    push_main(0, KPress, p);
    push_main(0, KLong, p + 10);
    wait_cyc(p + 12);
    @(negedge clk);
    check_bit("prereset_level", btn_level[0], 1'b1);
    reset = 1'b1;
    #1;
    check_zero("midhold_reset", {btn_level, press_pulse, release_pulse, long_press, repeat_pulse});
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cr = cyc;
    push_main(0, KPress, cr + 6);
    wait_cyc(cr + 5);
    @(negedge clk);
    check_bit("postreset_level_early", btn_level[0], 1'b0);
    wait_cyc(cr + 6);
    btn_raw[0] = 1'b0;
    push_main(0, KRelease, cr + 12);
    wait_cyc(cr + 22);

    // Repeat disabled: a single long press and nothing else while held.
    c = cyc;
    btn_raw_nr[0] = 1'b1;
    p = c + 6;
    push_nr(0, KPress, p);
    push_nr(0, KLong, p + 10);
    wait_cyc(p + 34);
    btn_raw_nr[0] = 1'b0;
    push_nr(0, KRelease, p + 40);
    wait_cyc(p + 50);

    check_empty("pending_main", q_main.size());
    check_empty("pending_norep", q_nr.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side counterpart to the seven-segment display path: turns raw, bouncy, asynchronous push-button inputs into clean, clock-synchronous signals.
- Outputs per button: debounced level, single-cycle press and release pulses, and a long-press pulse with auto-repeat.
- Feeds the mode/control fsm and the inc/dec counter (start_stop, reset, and later preset up/down buttons).
- Replaces the bare rising-edge detectors at the top level.

Parameters:
- N_BTN, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles the synchronized input must differ from the stable level before the level flips (10 ms at 100 MHz); must be >= 2.
- LONG_PRESS_CYCLES, 50000000, cycles from press_pulse to long_press (0.5 s); must be >= 1.
- REPEAT_CYCLES, 10000000, period of repeat_pulse while held after long_press; 0 disables repeat.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  N_BTN  raw button pins, asynchronous to clk.
- btn_level  output  N_BTN  debounced stable level.
- press_pulse  output  N_BTN  1-cycle pulse on debounced 0->1.
- release_pulse  output  N_BTN  1-cycle pulse on debounced 1->0.
- long_press  output  N_BTN  1-cycle pulse after LONG_PRESS_CYCLES held.
- repeat_pulse  output  N_BTN  1-cycle pulse every REPEAT_CYCLES while held past long_press.

Behaviour:
- Reset (async assert, sync release): sync flops, stable level, all counters and every output clear to 0; channel FSM goes to IDLE.
- Synchronizer: 2-flop chain per channel (sync1, sync2); no logic on sync1.
- Debounce, per channel:
  - deb_cnt increments each cycle sync2 != stable.
  - Any cycle with sync2 == stable clears deb_cnt.
  - On a mismatch cycle with deb_cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and deb_cnt <= 0.
- Latency: raw settles before edge 0 -> btn_level and press/release pulse go high after edge DEBOUNCE_CYCLES+1. Glitches shorter than DEBOUNCE_CYCLES produce no output.
- All outputs are registered. Pulses last exactly one cycle, and at most one of press/release/long/repeat is high per channel per cycle.
- Channel FSM: IDLE, PRESSED, HELD.
  - IDLE: on stable 0->1, assert press_pulse, clear hold_cnt, go to PRESSED.
  - PRESSED: hold_cnt++ each cycle. When hold_cnt == LONG_PRESS_CYCLES-1, assert long_press next cycle, clear hold_cnt, go to HELD. long_press therefore comes exactly LONG_PRESS_CYCLES cycles after press_pulse.
  - HELD with REPEAT_CYCLES > 0: hold_cnt++. When hold_cnt == REPEAT_CYCLES-1, assert repeat_pulse and clear hold_cnt. Pulses are periodic with period REPEAT_CYCLES.
  - HELD with REPEAT_CYCLES == 0: no repeat_pulse; stays in HELD.
  - Any state on stable 1->0: assert release_pulse, clear hold_cnt, go to IDLE.
- Simultaneous events: if release completes in the same cycle a long or repeat terminal count is reached, release wins and the long/repeat pulse is suppressed.
- Counter widths: $clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES, 2)) bits. Counters never wrap because they are cleared at the terminal count.
- Reset mid-press: after release, a held button is treated as a fresh press. It must debounce fully and then generate press_pulse; no release_pulse is generated for the pre-reset press.
- Button active at power-up: same as reset mid-press.
- Channels are fully independent; no cross-channel interaction.

Decomposition:
- Shared package button_pkg:
  - channel state enum (IDLE, PRESSED, HELD);
  - default timing constants DEBOUNCE_10MS_100MHZ, LONG_500MS_100MHZ, REPEAT_100MS_100MHZ;
  - a CNT_W width function.
- One sub-module, button_channel: synchronizer, debounce, and FSM for a single button.
- The top instantiates N_BTN copies via generate.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3.
- Clean press: btn_raw[0] 0->1 settled before edge 0 -> press_pulse[0] and btn_level[0] high after edge 5; press_pulse[0] low after edge 6; channel 1 all 0.
- Bounce: btn_raw toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during bounce; exactly one press_pulse 6 edges after the final settle.
- Long press and repeat: hold 30 cycles after press_pulse at cycle P -> long_press at P+10; repeat_pulse at P+13, P+16, ..., P+28; then release -> one release_pulse, btn_level 0, no further repeat.
- Release vs. long collision: arrange release debounce to complete at P+10 -> release_pulse only, long_press stays 0.
- Reset mid-hold: assert reset during HELD with the button still held -> all outputs 0 immediately (async); after deassert, press_pulse 6 edges later and no release_pulse.
- Repeat disabled (REPEAT_CYCLES=0): hold 40 cycles -> single long_press at P+10, no repeat_pulse.
